// File: rtl/key_event_if.sv
// Key event bus: debounced key level and acknowledge in, one-deep event register state out.
// master = key source plus event consumer, slave = key_event.
interface key_event_if;
    logic       key_n;
    logic       ev_ack;
    logic       ev_valid;
    logic [1:0] ev_code;
    logic       held;
    logic       ev_drop;

    modport master (
        output key_n,
        output ev_ack,
        input  ev_valid,
        input  ev_code,
        input  held,
        input  ev_drop
    );

    modport slave (
        input  key_n,
        input  ev_ack,
        output ev_valid,
        output ev_code,
        output held,
        output ev_drop
    );
endinterface

// File: rtl/key_event.sv
// Turns the debounced active-low key level into press / auto-repeat / release events.
// Latency: 3 CLK edges from a key_n change to the event in the output register.
// Backpressure: one-deep register; an event posted while an unacked one is held is dropped (ev_drop pulse).
module key_event #(
    parameter int LONG_CNT = 50_000_000,
    parameter int REP_CNT  = 10_000_000,
    parameter int CW       = 26
) (
    input  logic        CLK,
    input  logic        RESET,
    key_event_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        RPT  = 2'd2
    } state_t;

    localparam logic [1:0] EV_NONE    = 2'b00;
    localparam logic [1:0] EV_PRESS   = 2'b01;
    localparam logic [1:0] EV_REPEAT  = 2'b10;
    localparam logic [1:0] EV_RELEASE = 2'b11;

    localparam logic [CW-1:0] LONG_TC = CW'(LONG_CNT - 1);
    localparam logic [CW-1:0] REP_TC  = CW'(REP_CNT - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    // key_n comes from the debouncer's divided clock domain
    logic s1;
    logic s2;
    logic k;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
        end else begin
            s1 <= bus.key_n;
            s2 <= s1;
        end
    end

    assign k = ~s2;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_nxt;
    logic            post;
    logic [1:0]      post_code;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Release is tested first so it beats a terminal count in the same cycle.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        post      = 1'b0;
        post_code = EV_NONE;
        case (state)
            IDLE: begin
                if (k) begin
                    post      = 1'b1;
                    post_code = EV_PRESS;
                    cnt_nxt   = '0;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (!k) begin
                    post      = 1'b1;
                    post_code = EV_RELEASE;
                    state_nxt = IDLE;
                end else if (cnt == LONG_TC) begin
                    post      = 1'b1;
                    post_code = EV_REPEAT;
                    cnt_nxt   = '0;
                    state_nxt = RPT;
                end else begin
                    cnt_nxt   = cnt + CNT_ONE;
                end
            end
            RPT: begin
                if (!k) begin
                    post      = 1'b1;
                    post_code = EV_RELEASE;
                    state_nxt = IDLE;
                end else if (cnt == REP_TC) begin
                    post      = 1'b1;
                    post_code = EV_REPEAT;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt   = cnt + CNT_ONE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    logic       ev_valid_q;
    logic [1:0] ev_code_q;
    logic       ev_drop_q;
    logic       ev_load;
    logic       ev_lost;

    // A slot frees up on the same edge it is acked, giving one event per cycle with ack held high.
    assign ev_load = post && (!ev_valid_q || bus.ev_ack);
    assign ev_lost = post && ev_valid_q && !bus.ev_ack;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            ev_valid_q <= 1'b0;
            ev_code_q  <= EV_NONE;
            ev_drop_q  <= 1'b0;
        end else begin
            ev_drop_q <= ev_lost;
            if (ev_load) begin
                ev_valid_q <= 1'b1;
                ev_code_q  <= post_code;
            end else if (bus.ev_ack) begin
                ev_valid_q <= 1'b0;
            end
        end
    end

    assign bus.ev_valid = ev_valid_q;
    assign bus.ev_code  = ev_code_q;
    assign bus.ev_drop  = ev_drop_q;
    assign bus.held     = (state != IDLE);

endmodule

// File: tb/tb_key_event.sv
// Directed plus randomised bench for key_event, checked every cycle against a behavioural event model.
module tb_key_event;

    localparam int LONG = 8;
    localparam int REP  = 4;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    key_event_if bus ();

    key_event #(.LONG_CNT(LONG), .REP_CNT(REP), .CW(4)) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: key level as seen after a two-sample delay, plus the time since the press event.
    bit         kq[$];
    bit         m_pressed;
    int         m_age;
    logic       m_valid;
    logic [1:0] m_code;
    logic       m_drop;

    // Events observed on the DUT outputs
    int n_ev[4];
    int n_drop;
    logic prev_valid;
    logic ack_used;

    task automatic model_reset();
        kq = {1'b1, 1'b1};
        m_pressed = 1'b0;
        m_age = 0;
        m_valid = 1'b0;
        m_code = 2'b00;
        m_drop = 1'b0;
    endtask

    task automatic model_edge(input logic key_n, input logic ack);
        int   ev;
        bit   k;
        ev = 0;
        k = (kq[0] == 1'b0);
        if (!m_pressed && k) begin
            ev = 1;
            m_pressed = 1'b1;
            m_age = 0;
        end else if (m_pressed && !k) begin
            ev = 3;
            m_pressed = 1'b0;
        end else if (m_pressed) begin
            m_age++;
            if (m_age >= LONG && ((m_age - LONG) % REP) == 0) ev = 2;
        end
        m_drop = 1'b0;
        if (ev != 0) begin
            if (!m_valid || ack) begin
                m_valid = 1'b1;
                m_code = 2'(ev);
            end else begin
                m_drop = 1'b1;
            end
        end else if (ack) begin
            m_valid = 1'b0;
        end
        void'(kq.pop_front());
        kq.push_back(key_n);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare();
        chk("ev_valid", 32'(bus.ev_valid), 32'(m_valid));
        chk("ev_code",  32'(bus.ev_code),  32'(m_code));
        chk("held",     32'(bus.held),     32'(m_pressed));
        chk("ev_drop",  32'(bus.ev_drop),  32'(m_drop));
    endtask

    task automatic clear_counts();
        for (int i = 0; i < 4; i++) n_ev[i] = 0;
        n_drop = 0;
    endtask

    task automatic step();
        ack_used = bus.ev_ack;
        if (rst) model_edge(bus.key_n, bus.ev_ack);
        else model_reset();
        @(posedge clk);
        #1;
        compare();
        if (bus.ev_valid === 1'b1 && (!prev_valid || ack_used)) n_ev[bus.ev_code]++;
        if (bus.ev_drop === 1'b1) n_drop++;
        prev_valid = (bus.ev_valid === 1'b1);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Called #1 after an edge; reset lands mid-cycle, well away from either clock edge.
    task automatic async_reset(input int cycles);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        chk("rst_valid", 32'(bus.ev_valid), 32'd0);
        chk("rst_code",  32'(bus.ev_code),  32'd0);
        chk("rst_held",  32'(bus.held),     32'd0);
        chk("rst_drop",  32'(bus.ev_drop),  32'd0);
        prev_valid = 1'b0;
        steps(cycles);
        rst = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        prev_valid = 1'b0;
        ack_used = 1'b0;
        rst = 1'b1;
        bus.key_n = 1'b1;
        bus.ev_ack = 1'b0;
        model_reset();
        clear_counts();
        @(posedge clk);
        #1;

        // 1: reset, then idle with key released
        async_reset(3);
        clear_counts();
        steps(20);
        chk("idle_events", 32'(n_ev[1] + n_ev[2] + n_ev[3]), 32'd0);

        // 2: short press with a single ack pulse
        clear_counts();
        bus.key_n = 1'b0;
        steps(3);
        chk("sp_valid", 32'(bus.ev_valid), 32'd1);
        chk("sp_code",  32'(bus.ev_code),  32'd1);
        chk("sp_held",  32'(bus.held),     32'd1);
        bus.ev_ack = 1'b1;
        step();
        bus.ev_ack = 1'b0;
        chk("sp_acked", 32'(bus.ev_valid), 32'd0);
        steps(2);
        bus.key_n = 1'b1;
        steps(3);
        chk("sr_code", 32'(bus.ev_code), 32'd3);
        chk("sr_held", 32'(bus.held),    32'd0);
        steps(10);
        chk("sp_no_repeat", 32'(n_ev[2]), 32'd0);

        // 3: auto-repeat with ack tied high
        clear_counts();
        bus.ev_ack = 1'b1;
        bus.key_n = 1'b0;
        steps(31);
        bus.key_n = 1'b1;
        steps(5);
        chk("ar_press",   32'(n_ev[1]), 32'd1);
        chk("ar_repeats", 32'(n_ev[2]), 32'd6);
        chk("ar_release", 32'(n_ev[3]), 32'd1);
        chk("ar_drops",   32'(n_drop),  32'd0);
        bus.ev_ack = 1'b0;
        steps(2);

        // 4: back-pressure, release lost behind the unacked press
        clear_counts();
        bus.key_n = 1'b0;
        steps(3);
        bus.key_n = 1'b1;
        steps(6);
        chk("bp_code",  32'(bus.ev_code),  32'd1);
        chk("bp_valid", 32'(bus.ev_valid), 32'd1);
        chk("bp_drops", 32'(n_drop),       32'd1);
        chk("bp_held",  32'(bus.held),     32'd0);
        bus.ev_ack = 1'b1;
        step();
        bus.ev_ack = 1'b0;
        steps(2);

        // 5: ack on the edge the first repeat is posted
        clear_counts();
        bus.key_n = 1'b0;
        steps(10);
        bus.ev_ack = 1'b1;
        step();
        bus.ev_ack = 1'b0;
        chk("sim_valid", 32'(bus.ev_valid), 32'd1);
        chk("sim_code",  32'(bus.ev_code),  32'd2);
        chk("sim_drop",  32'(bus.ev_drop),  32'd0);
        bus.key_n = 1'b1;
        steps(4);
        bus.ev_ack = 1'b1;
        step();
        bus.ev_ack = 1'b0;

        // 6: reset while repeating, key still held afterwards
        bus.ev_ack = 1'b1;
        bus.key_n = 1'b0;
        steps(14);
        async_reset(5);
        clear_counts();
        steps(2);
        chk("rr_quiet", 32'(bus.ev_valid), 32'd0);
        step();
        chk("rr_press_valid", 32'(bus.ev_valid), 32'd1);
        chk("rr_press_code",  32'(bus.ev_code),  32'd1);
        steps(3);
        chk("rr_no_release", 32'(n_ev[3]), 32'd0);
        bus.key_n = 1'b1;
        steps(4);

        // Random key levels and ack patterns with occasional resets
        for (int seg = 0; seg < 120; seg++) begin
            int len;
            int ack_mode;
            bus.key_n = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 26);
            ack_mode = $urandom_range(0, 3);
            for (int c = 0; c < len; c++) begin
                case (ack_mode)
                    0: bus.ev_ack = 1'b0;
                    1: bus.ev_ack = 1'b1;
                    default: bus.ev_ack = 1'($urandom_range(0, 1));
                endcase
                step();
            end
            if ($urandom_range(0, 19) == 0) async_reset($urandom_range(1, 4));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/key_event.md
# key_event

Consumer-side companion to the push-button debouncer: takes the debounced, active-low key level and turns it into discrete key events for the VGA lesson logic. Events are press, auto-repeat and release. Each event is held in a one-deep output register with a valid/ack handshake. The input is synchronised into the CLK domain, because the debouncer output is produced from a divided clock.

## Interface
- `LONG_CNT`, default 50_000_000: CLK cycles from the press event to the first repeat event (1 s at 50 MHz); legal range ≥2.
- `REP_CNT`, default 10_000_000: CLK cycles between subsequent repeat events (200 ms at 50 MHz); legal range ≥2.
- `CW`, default 26: hold-counter width. Both `LONG_CNT` and `REP_CNT` must be < 2^CW.
- `CLK`, in, 1: system clock, rising edge.
- `RESET`, in, 1: reset, asynchronous, active-low.
- `key_n`, in, 1: debounced key level; '0' means pressed. Asynchronous to CLK.
- `ev_ack`, in, 1: consumer accepts the current event.
- `ev_valid`, out, 1: event register holds an unaccepted event.
- `ev_code`, out, 2: event type: 01 press, 10 repeat, 11 release. 00 only after reset.
- `held`, out, 1: key is considered pressed (FSM not in IDLE).
- `ev_drop`, out, 1: one-cycle pulse when an event is lost because the register is full.

## Operation
- **Synchroniser:** two flops, `s1` <= `key_n`, `s2` <= `s1`. Both reset to 1 (released). Internal `k = ~s2`.
- **FSM states:** IDLE, HOLD, RPT. Single counter `cnt[CW-1:0]`.
- **IDLE:**
  - `k=1`: post PRESS, `cnt`<=0, go to HOLD.
  - Otherwise stay in IDLE.
- **HOLD:**
  - `k=0`: post RELEASE, go to IDLE.
  - Else if `cnt==LONG_CNT-1`: post REPEAT, `cnt`<=0, go to RPT.
  - Else `cnt`<=`cnt`+1.
- **RPT:**
  - `k=0`: post RELEASE, go to IDLE.
  - Else if `cnt==REP_CNT-1`: post REPEAT, `cnt`<=0.
  - Else `cnt`<=`cnt`+1.
- **Priority:** release (`k=0`) wins over a counter terminal count in the same cycle.
- **`held`:** 1 in HOLD and RPT, 0 in IDLE.
- **Event register (one deep):**
  - A posted event loads `ev_code` and sets `ev_valid` when `ev_valid==0`, or when `ev_valid==1 && ev_ack==1` in the same cycle.
  - If `ev_valid==1 && ev_ack==0`, the posted event is discarded and `ev_drop`=1 for one cycle. `ev_code` is unchanged. The FSM still advances.
  - `ev_ack` with no posted event clears `ev_valid`; `ev_code` keeps its last value.
  - `ev_ack` while `ev_valid==0` is ignored.
- **Counter:** `cnt` never exceeds `max(LONG_CNT,REP_CNT)-1`, so no wrap. Its value is don't-care in IDLE.

## Timing
- **Reset values:** `ev_valid`=0, `ev_code`=00, `held`=0, `ev_drop`=0, state IDLE, `cnt`=0, `s1`=`s2`=1.
- **Press latency:** `key_n` is sampled 0 at edge E. `s2`=0 after E+1. `ev_valid`=1, `ev_code`=01 and `held`=1 after E+2.
- **Release latency:** same 3-edge latency, on the 0→1 edge of `key_n`.
- **First repeat:** becomes visible exactly `LONG_CNT` cycles after the press event became visible, if `k` stays 1.
- **Later repeats:** every `REP_CNT` cycles.
- **Handshake:** the consumer samples `ev_code` while `ev_valid=1`. The event is consumed on the edge where `ev_ack=1`.
- **Back-to-back throughput:** one event per cycle, with `ev_ack` held high.
- **`ev_drop`:** asserted on the same edge the lost event would have loaded.
- **RESET mid-operation:**
  - Immediate return to reset values; any pending event is lost and no release event is generated.
  - If the key is still pressed when RESET releases, a fresh PRESS appears 3 edges later.

## Test plan
Benches use `LONG_CNT`=8, `REP_CNT`=4, `CW`=4.
1. **Reset:** assert RESET=0 mid-clock → all outputs 0 immediately. Release with `key_n`=1 for 20 cycles → no event.
2. **Short press:** `key_n`=0 at edge 0 → `ev_valid`=1, `ev_code`=01, `held`=1 after edge 2. `ev_ack` pulse at edge 3 → `ev_valid`=0. `key_n`=1 at edge 6 → `ev_code`=11 after edge 8, `held`=0. No repeat event at any point.
3. **Auto-repeat:** hold `key_n`=0 for 30 cycles with `ev_ack` tied high → press at edge 2, repeats at edges 10, 14, 18, 22, 26, 30, then release 3 edges after `key_n` rises.
4. **Back-pressure:** `ev_ack`=0; press, then release 3 cycles later → `ev_code` stays 01, `ev_drop` pulses once at release, `held`=0.
5. **Simultaneous ack and event:** `ev_ack`=1 on the same edge a repeat is posted → `ev_valid` stays 1, `ev_code`=10, `ev_drop`=0.
6. **Reset mid-operation:** RESET=0 during RPT with key held, released 5 cycles later → outputs reset, no release event, PRESS (01) 3 edges after RESET rises.
